reset_release_sequencer: RTL and testbench
==========================================

Name: reset_release_sequencer

Overview:
- Downstream consumer of the fabric reset generator's FABRIC_RESET_N.
- Once the fabric is out of reset, releases NUM_STAGES subsystem resets in fixed order (stage 0 first), each after a programmable delay.
- Each stage must return a ready handshake before the next stage is released; a missing ready is flagged as a timeout error.
- Also accepts a software-requested re-sequence, so subsystems can be re-reset without a device-level reset.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs; legal range 1..16.
- HOLD_CYCLES, 8, cycles all stage resets stay asserted after FABRIC_RESET_N deasserts or after SW_RST_REQ; must be ≥1.
- STAGE_DELAY, 16, cycles spent in DELAY before each stage release; must be ≥1.
- TIMEOUT, 1024, maximum consecutive WAIT cycles without STAGE_READY[k] before error; must be ≥1.

Ports:
- CLK  in  1  single clock for the whole block.
- FABRIC_RESET_N  in  1  synchronous, active-low reset.
- SW_RST_REQ  in  1  single-cycle request to re-run the full sequence.
- STAGE_READY  in  NUM_STAGES  per-stage ready acknowledge; synchronous to CLK (any synchronizers live outside this block).
- STAGE_RESET_N  out  NUM_STAGES  per-stage active-low reset outputs.
- BUSY  out  1  high while the sequence is in progress (HOLD, DELAY or WAIT).
- SEQ_DONE  out  1  high when all stages are released and acknowledged.
- SEQ_ERROR  out  1  high after a stage timeout.
- ERR_STAGE  out  4  index of the stage that timed out.

Behaviour:
- Reset interface (already decided): one clock, CLK; reset is synchronous and active-low, FABRIC_RESET_N.
- Reset: FABRIC_RESET_N low at a CLK posedge forces:
  - state=HOLD, stage index k=0, all counters=0;
  - STAGE_RESET_N=all 0, BUSY=1, SEQ_DONE=0, SEQ_ERROR=0, ERR_STAGE=0.
- Reset mid-sequence: returns to the reset values above immediately on that edge.
- Cycle numbering: cycle 0 is the first cycle with FABRIC_RESET_N high.
- HOLD:
  - Counts HOLD_CYCLES cycles (cycles 0..H-1), then enters DELAY with k=0.
  - SW_RST_REQ seen in HOLD is ignored; it does not restart or extend the count.
- DELAY:
  - Counts STAGE_DELAY cycles.
  - On the last count, sets STAGE_RESET_N[k]=1 and enters WAIT; the output is first high in the first WAIT cycle.
- WAIT:
  - STAGE_READY[k] is sampled every cycle, including the first WAIT cycle.
  - Ready high with k<NUM_STAGES-1: next cycle k=k+1, enter DELAY.
  - Ready high with k=NUM_STAGES-1: next cycle enter DONE.
  - Ready low for TIMEOUT consecutive WAIT cycles: next cycle enter ERROR.
- Release timing:
  - Stage k first high at cycle H+D+k*(D+1); every stage after the first costs D+1 cycles.
  - SEQ_DONE first high at cycle H+D+(N-1)*(D+1)+1, assuming ready is immediate at every stage.
- DONE:
  - BUSY=0, SEQ_DONE=1, all STAGE_RESET_N=1.
  - STAGE_READY is ignored.
- ERROR:
  - STAGE_RESET_N[k..N-1]=0; stages below k stay released.
  - SEQ_ERROR=1, ERR_STAGE=k, BUSY=0, SEQ_DONE=0.
  - The block stays in ERROR until SW_RST_REQ or FABRIC_RESET_N low.
- SW_RST_REQ in DELAY, WAIT, DONE or ERROR:
  - Next cycle: state=HOLD, k=0, counters=0.
  - All STAGE_RESET_N=0, SEQ_DONE=0, SEQ_ERROR=0, ERR_STAGE=0, BUSY=1.
- Simultaneous events:
  - SW_RST_REQ together with STAGE_READY or a timeout: SW_RST_REQ wins.
  - FABRIC_RESET_N low overrides everything.
- Output coding:
  - All outputs are registered; no combinational path from any input to any output.
  - STAGE_READY bits for stages other than k are ignored at all times.
  - ERR_STAGE is zero-extended from the stage index.

Test Plan:
1. Defaults, STAGE_READY tied all 1, release FABRIC_RESET_N -> STAGE_RESET_N[0..3] rise at cycles 24, 41, 58, 75; SEQ_DONE and BUSY=0 at cycle 76.
2. STAGE_READY[1] raised 5 cycles after STAGE_RESET_N[1] rises (cycle 46) -> DELAY for stage 2 starts cycle 47; STAGE_RESET_N[2] rises at cycle 63.
3. STAGE_READY[0] never asserted -> WAIT covers cycles 24..1047; at cycle 1048 SEQ_ERROR=1, ERR_STAGE=0, STAGE_RESET_N=0000, BUSY=0.
4. SW_RST_REQ pulse in DONE -> next cycle STAGE_RESET_N=0000, SEQ_DONE=0, BUSY=1; full sequence repeats with the same offsets relative to the pulse.
5. FABRIC_RESET_N low for 1 cycle while in WAIT for stage 2 -> on that edge all outputs return to reset values; sequence restarts at cycle 0 afterwards.
6. SW_RST_REQ in the same cycle STAGE_READY[3] goes high -> HOLD entered, SEQ_DONE stays 0; a SW_RST_REQ issued during HOLD leaves the HOLD count unchanged.

Source files
------------

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
// Releases NUM_STAGES subsystem resets in order once the fabric leaves reset.
// Each stage is released after STAGE_DELAY cycles and must return STAGE_READY
// within TIMEOUT cycles. A missing ready latches an error. SW_RST_REQ re-runs
// the whole sequence without a device-level reset.
// All outputs are registered from the next-state values, so the outputs always
// describe the state the block is currently in.
module reset_release_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                  CLK,
  input  logic                  FABRIC_RESET_N,
  input  logic                  SW_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_READY,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  BUSY,
  output logic                  SEQ_DONE,
  output logic                  SEQ_ERROR,
  output logic [3:0]            ERR_STAGE
);

  localparam int unsigned K_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned MAX_HD  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int unsigned CNT_MAX = (MAX_HD > TIMEOUT) ? MAX_HD : TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST       = K_W'(NUM_STAGES - 1);

  localparam logic [2:0] ST_HOLD  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [K_W-1:0]        k_q;
  logic [K_W-1:0]        k_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NUM_STAGES-1:0] release_d;
  logic                  ready_k;
  logic                  sw_restart;

  // Only the ready bit of the stage currently being waited on matters.
  assign ready_k = STAGE_READY[k_q];

  // A software request restarts the sequence from any state except HOLD.
  assign sw_restart = SW_RST_REQ && (state_q != ST_HOLD);

  // Next-state, stage index and shared cycle counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    if (sw_restart) begin
      state_d = ST_HOLD;
      k_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_DELAY;
            k_d     = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (ready_k) begin
            cnt_d = '0;
            if (k_q == K_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DELAY;
              k_d     = k_q + K_W'(1);
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_ERROR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_HOLD;
          k_d     = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage release mask for the next state: stages below k are always out of
  // reset once sequencing has passed them; stage k itself is out only while
  // waiting for its ready. The timed-out stage is pulled back into reset.
  always_comb begin
    release_d = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      case (state_d)
        ST_DONE:  release_d[i] = 1'b1;
        ST_DELAY: release_d[i] = (K_W'(i) < k_d);
        ST_WAIT:  release_d[i] = (K_W'(i) <= k_d);
        ST_ERROR: release_d[i] = (K_W'(i) < k_d);
        default:  release_d[i] = 1'b0;
      endcase
    end
  end

  // State and registered outputs, synchronous active-low fabric reset.
  always_ff @(posedge CLK) begin
    if (!FABRIC_RESET_N) begin
      state_q       <= ST_HOLD;
      k_q           <= '0;
      cnt_q         <= '0;
      STAGE_RESET_N <= '0;
      BUSY          <= 1'b1;
      SEQ_DONE      <= 1'b0;
      SEQ_ERROR     <= 1'b0;
      ERR_STAGE     <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      STAGE_RESET_N <= release_d;
      BUSY          <= (state_d == ST_HOLD) || (state_d == ST_DELAY) || (state_d == ST_WAIT);
      SEQ_DONE      <= (state_d == ST_DONE);
      SEQ_ERROR     <= (state_d == ST_ERROR);
      ERR_STAGE     <= (state_d == ST_ERROR) ? 4'(k_d) : 4'd0;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Testbench for reset_release_sequencer. The reference model tracks the
// sequence by timestamps (sequence start, release cycle of the current stage)
// rather than by a state machine.
module tb_reset_release_sequencer;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int D  = 16;
  localparam int TO = 1024;

  localparam int M_SEQ  = 0;
  localparam int M_DONE = 1;
  localparam int M_ERR  = 2;

  logic         CLK = 1'b0;
  logic         rstn;
  logic         req;
  logic [N-1:0] ready;
  logic [N-1:0] STAGE_RESET_N;
  logic         BUSY;
  logic         SEQ_DONE;
  logic         SEQ_ERROR;
  logic [3:0]   ERR_STAGE;
  logic [10:0]  obs;

  int n_cmp = 0;
  int n_err = 0;

  // Model: absolute cycle of the current observation, start of the running
  // sequence, cycle at which stage m_k rises, and the overall mode.
  int m_cyc   = 0;
  int m_start = 0;
  int m_trel  = H + D;
  int m_k     = 0;
  int m_mode  = M_SEQ;

  always #5 CLK = ~CLK;

  assign obs = {STAGE_RESET_N, BUSY, SEQ_DONE, SEQ_ERROR, ERR_STAGE};

  reset_release_sequencer #(
    .NUM_STAGES (N),
    .HOLD_CYCLES(H),
    .STAGE_DELAY(D),
    .TIMEOUT    (TO)
  ) dut (
    .CLK           (CLK),
    .FABRIC_RESET_N(rstn),
    .SW_RST_REQ    (req),
    .STAGE_READY   (ready),
    .STAGE_RESET_N (STAGE_RESET_N),
    .BUSY          (BUSY),
    .SEQ_DONE      (SEQ_DONE),
    .SEQ_ERROR     (SEQ_ERROR),
    .ERR_STAGE     (ERR_STAGE)
  );

  function automatic logic [10:0] expected();
    logic [N-1:0] rel;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   es;
    rel  = '0;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    es   = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (m_mode == M_DONE) rel[i] = 1'b1;
      else if (i < m_k) rel[i] = 1'b1;
      else if (m_mode == M_SEQ && i == m_k && m_cyc >= m_trel) rel[i] = 1'b1;
    end
    if (m_mode == M_SEQ) busy = 1'b1;
    if (m_mode == M_DONE) done = 1'b1;
    if (m_mode == M_ERR) begin
      err = 1'b1;
      es  = 4'(m_k);
    end
    return {rel, busy, done, err, es};
  endfunction

  function automatic int rc();
    return m_cyc - m_start;
  endfunction

  task automatic restart_model(input int first_cycle);
    m_mode  = M_SEQ;
    m_k     = 0;
    m_start = first_cycle;
    m_trel  = first_cycle + H + D;
  endtask

  // Apply the rules to the inputs present during cycle m_cyc.
  task automatic model_edge();
    int c;
    c = m_cyc;
    if (!rstn) begin
      restart_model(c + 1);
    end else if (req && !(m_mode == M_SEQ && c < m_start + H)) begin
      restart_model(c + 1);
    end else if (m_mode == M_SEQ && c >= m_trel) begin
      if (ready[m_k]) begin
        if (m_k == N - 1) m_mode = M_DONE;
        else begin
          m_k    = m_k + 1;
          m_trel = c + 1 + D;
        end
      end else if (c - m_trel + 1 >= TO) begin
        m_mode = M_ERR;
      end
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic hold_reset(input int cycles);
    rstn = 1'b0;
    req  = 1'b0;
    repeat (cycles) step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    req   = 1'b0;
    ready = '1;
    repeat (3) begin
      step();
      n_cmp++;
      if (obs !== 11'b0000_1_0_0_0000) begin
        n_err++;
        $display("FAIL reset_values: got %b want %b", obs, 11'b0000_1_0_0_0000);
      end
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL reset_model: got %b want %b", obs, expected());
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_nominal();
    hold_reset(2);
    ready = '1;
    for (int n = 0; n < 80; n++) begin
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL nominal cyc %0d: got %b want %b", rc(), obs, expected());
      end
      case (rc())
        23, 24, 40, 41, 58, 75: begin
          logic [N-1:0] want;
          want = (rc() == 23) ? 4'b0000 : (rc() == 24) ? 4'b0001 :
                 (rc() == 40) ? 4'b0001 : (rc() == 41) ? 4'b0011 :
                 (rc() == 58) ? 4'b0111 : 4'b1111;
          n_cmp++;
          if (STAGE_RESET_N !== want) begin
            n_err++;
            $display("FAIL nominal_release cyc %0d: got %b want %b", rc(), STAGE_RESET_N, want);
          end
        end
        76: begin
          n_cmp++;
          if ({SEQ_DONE, BUSY} !== 2'b10) begin
            n_err++;
            $display("FAIL nominal_done cyc 76: got done,busy=%b want 10", {SEQ_DONE, BUSY});
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_late_ready();
    hold_reset(2);
    ready = 4'b1101;
    for (int n = 0; n < 70; n++) begin
      ready = (rc() >= 46) ? 4'b1111 : 4'b1101;
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL late_ready cyc %0d: got %b want %b", rc(), obs, expected());
      end
      if (rc() == 47 || rc() == 62 || rc() == 63) begin
        logic [N-1:0] want;
        want = (rc() == 63) ? 4'b0111 : 4'b0011;
        n_cmp++;
        if (STAGE_RESET_N !== want) begin
          n_err++;
          $display("FAIL late_ready_release cyc %0d: got %b want %b", rc(), STAGE_RESET_N, want);
        end
      end
    end
  endtask

  task automatic test_timeout_recover();
    hold_reset(2);
    ready = '0;
    for (int n = 0; n < 1049; n++) begin
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL timeout cyc %0d: got %b want %b", rc(), obs, expected());
      end
      if (rc() == 1047) begin
        n_cmp++;
        if (obs !== 11'b0001_1_0_0_0000) begin
          n_err++;
          $display("FAIL timeout_last_wait: got %b want %b", obs, 11'b0001_1_0_0_0000);
        end
      end
      if (rc() == 1048) begin
        n_cmp++;
        if (obs !== 11'b0000_0_0_1_0000) begin
          n_err++;
          $display("FAIL timeout_error: got %b want %b", obs, 11'b0000_0_0_1_0000);
        end
      end
    end
    req = 1'b1;
    step();
    req = 1'b0;
    n_cmp++;
    if (obs !== 11'b0000_1_0_0_0000) begin
      n_err++;
      $display("FAIL error_sw_restart: got %b want %b", obs, 11'b0000_1_0_0_0000);
    end
    ready = '1;
    for (int n = 0; n < 30; n++) begin
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL error_recover cyc %0d: got %b want %b", rc(), obs, expected());
      end
    end
  endtask

  task automatic test_sw_in_done();
    hold_reset(2);
    ready = '1;
    repeat (80) step();
    n_cmp++;
    if (SEQ_DONE !== 1'b1) begin
      n_err++;
      $display("FAIL done_before_req: got %b want 1", SEQ_DONE);
    end
    req = 1'b1;
    step();
    req = 1'b0;
    n_cmp++;
    if (obs !== 11'b0000_1_0_0_0000) begin
      n_err++;
      $display("FAIL done_sw_restart: got %b want %b", obs, 11'b0000_1_0_0_0000);
    end
    for (int n = 0; n < 80; n++) begin
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL rerun cyc %0d: got %b want %b", rc(), obs, expected());
      end
      if (rc() == 24) begin
        n_cmp++;
        if (STAGE_RESET_N !== 4'b0001) begin
          n_err++;
          $display("FAIL rerun_stage0: got %b want 0001", STAGE_RESET_N);
        end
      end
      if (rc() == 76) begin
        n_cmp++;
        if ({SEQ_DONE, BUSY} !== 2'b10) begin
          n_err++;
          $display("FAIL rerun_done: got done,busy=%b want 10", {SEQ_DONE, BUSY});
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    hold_reset(2);
    ready = 4'b0011;
    while (rc() < 61) step();
    n_cmp++;
    if (obs !== 11'b0111_1_0_0_0000) begin
      n_err++;
      $display("FAIL wait_stage2: got %b want %b", obs, 11'b0111_1_0_0_0000);
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_cmp++;
    if (obs !== 11'b0000_1_0_0_0000) begin
      n_err++;
      $display("FAIL mid_reset_values: got %b want %b", obs, 11'b0000_1_0_0_0000);
    end
    ready = '1;
    for (int n = 0; n < 30; n++) begin
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL mid_reset_restart cyc %0d: got %b want %b", rc(), obs, expected());
      end
      if (rc() == 24) begin
        n_cmp++;
        if (STAGE_RESET_N !== 4'b0001) begin
          n_err++;
          $display("FAIL mid_reset_stage0: got %b want 0001", STAGE_RESET_N);
        end
      end
    end
  endtask

  task automatic test_sw_collision();
    hold_reset(2);
    ready = 4'b0111;
    while (rc() < 77) step();
    ready = 4'b1111;
    req   = 1'b1;
    step();
    req   = 1'b0;
    n_cmp++;
    if (obs !== 11'b0000_1_0_0_0000) begin
      n_err++;
      $display("FAIL collision_restart: got %b want %b", obs, 11'b0000_1_0_0_0000);
    end
    for (int n = 0; n < 26; n++) begin
      req = (rc() == 3);
      step();
      req = 1'b0;
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL hold_req cyc %0d: got %b want %b", rc(), obs, expected());
      end
      if (rc() == 23 || rc() == 24) begin
        logic [N-1:0] want;
        want = (rc() == 24) ? 4'b0001 : 4'b0000;
        n_cmp++;
        if (STAGE_RESET_N !== want) begin
          n_err++;
          $display("FAIL hold_req_release cyc %0d: got %b want %b", rc(), STAGE_RESET_N, want);
        end
      end
    end
  endtask

  task automatic test_random();
    hold_reset(2);
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < N; b++) ready[b] = ($urandom_range(0, 7) == 0);
      req  = ($urandom_range(0, 149) == 0);
      rstn = ($urandom_range(0, 599) != 0);
      step();
      n_cmp++;
      if (obs !== expected()) begin
        n_err++;
        $display("FAIL random n=%0d cyc %0d: got %b want %b", n, rc(), obs, expected());
      end
    end
    rstn = 1'b1;
    req  = 1'b0;
  endtask

  initial begin
    rstn  = 1'b0;
    req   = 1'b0;
    ready = '0;
    test_reset();
    test_nominal();
    test_late_ready();
    test_timeout_recover();
    test_sw_in_done();
    test_reset_mid_wait();
    test_sw_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
